// File: rtl/core_pkg.sv
// Types and defaults shared by decode, the register file and writeback.
package core_pkg;
    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_ZERO      = 0;

    typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0]          xlen_t;
endpackage

// File: rtl/regfile_wr_arb.sv
// Matches one query address against all write ports.
// The highest-index hit wins. Also flags colliding writes to any non-zero register.
module regfile_wr_arb
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [AW-1:0]       addr,
    output logic                hit,
    output logic [XLEN-1:0]     data,
    output logic                conflict
);
    always_comb begin
        hit      = 1'b0;
        data     = '0;
        conflict = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            // Later ports overwrite earlier ones, giving highest-index priority.
            if (wr_en[j] && wr_addr[j*AW +: AW] == addr) begin
                hit  = 1'b1;
                data = wr_data[j*XLEN +: XLEN];
            end
            for (int i = j + 1; i < NWR; i++) begin
                if (wr_en[i] && wr_en[j] &&
                    wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW] &&
                    wr_addr[j*AW +: AW] != AW'(REG_ZERO))
                    conflict = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file for the pipelined core.
// Includes a pending-bit scoreboard for detecting RAW and WAW hazards at issue.
module regfile_mp
    import core_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ok,
    output logic                wr_conflict
);
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;

    logic             iss_hit;
    logic             iss_conf;
    logic [XLEN-1:0]  iss_data_unused;
    logic             iss_zero;
    logic             iss_set;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic            hit;
        logic [XLEN-1:0] byp;
        logic            conf_unused;
        logic [XLEN-1:0] d;
        logic            b;

        assign a = rd_addr[k*AW +: AW];

        regfile_wr_arb #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_arb (
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .addr     (a),
            .hit      (hit),
            .data     (byp),
            .conflict (conf_unused)
        );

        // Reset also masks the bypass path so reads are zero while rst is held.
        always_comb begin
            d = regs[a];
            b = pending[a];
            if (rst || (ZERO_REG != 0 && a == AW'(REG_ZERO))) begin
                d = '0;
                b = 1'b0;
            end else if (BYPASS != 0 && hit) begin
                d = byp;
                b = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = d;
        assign rd_busy[k]              = b;
    end

    regfile_wr_arb #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_iss_arb (
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .addr     (iss_addr),
        .hit      (iss_hit),
        .data     (iss_data_unused),
        .conflict (iss_conf)
    );

    assign iss_zero = (ZERO_REG != 0) && (iss_addr == AW'(REG_ZERO));

    // A pending destination may be reissued only when its producer retires this cycle.
    always_comb begin
        iss_ok = !pending[iss_addr] || iss_hit;
        if (rst || iss_zero)
            iss_ok = 1'b1;
    end

    assign iss_set = iss_en && iss_ok && !iss_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            pending     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    if (!(ZERO_REG != 0 && wr_addr[j*AW +: AW] == AW'(REG_ZERO)))
                        regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                    pending[wr_addr[j*AW +: AW]] <= 1'b0;
                end
            end
            if (iss_set)
                pending[iss_addr] <= 1'b1;
            wr_conflict <= iss_conf;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed hazard/priority cases plus a randomised model comparison.
// Runs a bypassing and a non-bypassing instance in parallel.
module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
    logic [NRD-1:0]      rd_busy, rd_busy_nb;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                iss_ok, iss_ok_nb;
    logic                wr_conflict, wr_conflict_nb;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .iss_ok(iss_ok), .wr_conflict(wr_conflict)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .iss_ok(iss_ok_nb), .wr_conflict(wr_conflict_nb)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];

    localparam int S_D0 = 0, S_D1 = 1, S_BUSY = 2, S_ISS = 3, S_CONF = 4,
                   S_NB_D0 = 5, S_NB_D1 = 6, S_NB_BUSY = 7, S_NB_ISS = 8;

    task automatic push(input string tag, input int sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] obs(input int sel);
        case (sel)
            S_D0:      return 64'(rd_data[31:0]);
            S_D1:      return 64'(rd_data[63:32]);
            S_BUSY:    return 64'(rd_busy);
            S_ISS:     return 64'(iss_ok);
            S_CONF:    return 64'(wr_conflict);
            S_NB_D0:   return 64'(rd_data_nb[31:0]);
            S_NB_D1:   return 64'(rd_data_nb[63:32]);
            S_NB_BUSY: return 64'(rd_busy_nb);
            S_NB_ISS:  return 64'(iss_ok_nb);
            default:   return 'x;
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.exp);
        end
    endtask

    // Sample on the falling edge, then advance to just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        rd_addr  = '0;
    endtask

    task automatic wr(input int port, input int a, input logic [31:0] d);
        wr_en[port]                = 1'b1;
        wr_addr[port*AW +: AW]     = AW'(a);
        wr_data[port*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int port, input int a);
        rd_addr[port*AW +: AW] = AW'(a);
    endtask

    logic [31:0]      m_regs [NREGS];
    logic [NREGS-1:0] m_pend;
    logic             m_conf;

    task automatic model_step();
        logic [AW-1:0] a;
        logic          hit, ok, conf_n;
        logic [31:0]   hd;
        for (int k = 0; k < NRD; k++) begin
            a   = rd_addr[k*AW +: AW];
            hit = 1'b0;
            hd  = '0;
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
                    hit = 1'b1;
                    hd  = wr_data[j*XLEN +: XLEN];
                end
            if (a == 0) begin
                push("rnd_d",    S_D0 + k,    64'h0);
                push("rnd_nb_d", S_NB_D0 + k, 64'h0);
            end else begin
                push("rnd_d",    S_D0 + k,    64'(hit ? hd : m_regs[a]));
                push("rnd_nb_d", S_NB_D0 + k, 64'(m_regs[a]));
            end
        end
        push("rnd_busy", S_BUSY, {62'h0,
             (rd_addr[AW +: AW] != 0 && !(wr_en[0] && wr_addr[0 +: AW] == rd_addr[AW +: AW])
                 && !(wr_en[1] && wr_addr[AW +: AW] == rd_addr[AW +: AW])) ? m_pend[rd_addr[AW +: AW]] : 1'b0,
             (rd_addr[0 +: AW] != 0 && !(wr_en[0] && wr_addr[0 +: AW] == rd_addr[0 +: AW])
                 && !(wr_en[1] && wr_addr[AW +: AW] == rd_addr[0 +: AW])) ? m_pend[rd_addr[0 +: AW]] : 1'b0});
        push("rnd_nb_busy", S_NB_BUSY, {62'h0,
             rd_addr[AW +: AW] != 0 ? m_pend[rd_addr[AW +: AW]] : 1'b0,
             rd_addr[0 +: AW]  != 0 ? m_pend[rd_addr[0 +: AW]]  : 1'b0});
        hit = (wr_en[0] && wr_addr[0 +: AW] == iss_addr) || (wr_en[1] && wr_addr[AW +: AW] == iss_addr);
        ok  = (iss_addr == 0) || !m_pend[iss_addr] || hit;
        push("rnd_iss",    S_ISS,    64'(ok));
        push("rnd_nb_iss", S_NB_ISS, 64'(ok));
        push("rnd_conf",   S_CONF,   64'(m_conf));
        conf_n = wr_en[0] && wr_en[1] && wr_addr[0 +: AW] == wr_addr[AW +: AW] && wr_addr[0 +: AW] != 0;
        cycle();
        for (int j = 0; j < NWR; j++)
            if (wr_en[j]) begin
                if (wr_addr[j*AW +: AW] != 0)
                    m_regs[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                m_pend[wr_addr[j*AW +: AW]] = 1'b0;
            end
        if (iss_en && ok && iss_addr != 0)
            m_pend[iss_addr] = 1'b1;
        m_conf = conf_n;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // Bypass must not leak through while reset is held.
        wr(0, 4, 32'hABC);
        rd(0, 4);
        iss_addr = 5'd4;
        push("rst_d0",   S_D0,   64'h0);
        push("rst_busy", S_BUSY, 64'h0);
        push("rst_iss",  S_ISS,  64'h1);
        @(negedge clk);
        drain();
        idle();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Write r5 and issue r5 together: value lands and r5 becomes pending.
        wr(0, 5, 32'hDEAD);
        iss_en   = 1'b1;
        iss_addr = 5'd5;
        push("pre_iss5", S_ISS, 64'h1);
        cycle();
        idle();
        rd(0, 5);
        iss_addr = 5'd5;
        push("r5_data", S_D0,   64'hDEAD);
        push("r5_busy", S_BUSY, 64'h1);
        push("r5_iss",  S_ISS,  64'h0);
        @(negedge clk);
        drain();
        #2 rst = 1'b1;
        #1;
        push("async_rst_d0",   S_D0,   64'h0);
        push("async_rst_busy", S_BUSY, 64'h0);
        drain();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int r = 0; r < NREGS; r++) begin
            rd(0, r);
            rd(1, r);
            iss_addr = AW'(r);
            push("post_rst_busy", S_BUSY, 64'h0);
            push("post_rst_iss",  S_ISS,  64'h1);
            push("post_rst_d1",   S_D1,   64'h0);
            cycle();
        end

        // Zero register: both ports write r0, issue to r0.
        idle();
        wr(0, 0, 32'hFFFF_FFFF);
        wr(1, 0, 32'h1234_5678);
        iss_en = 1'b1;
        push("zero_d0",   S_D0,   64'h0);
        push("zero_d1",   S_D1,   64'h0);
        push("zero_busy", S_BUSY, 64'h0);
        push("zero_iss",  S_ISS,  64'h1);
        cycle();
        idle();
        push("zero_d0_after",   S_D0,   64'h0);
        push("zero_busy_after", S_BUSY, 64'h0);
        push("zero_iss_after",  S_ISS,  64'h1);
        push("zero_no_conf",    S_CONF, 64'h0);
        cycle();

        // Priority: two ports write r7 in the same cycle.
        wr(0, 7, 32'h11);
        wr(1, 7, 32'h22);
        rd(0, 7);
        rd(1, 7);
        push("prio_byp_d0", S_D0,    64'h22);
        push("prio_byp_d1", S_D1,    64'h22);
        push("prio_nb_d0",  S_NB_D0, 64'h0);
        push("prio_conf0",  S_CONF,  64'h0);
        cycle();
        idle();
        rd(0, 7);
        push("prio_d0_next", S_D0,    64'h22);
        push("prio_nb_next", S_NB_D0, 64'h22);
        push("prio_conf1",   S_CONF,  64'h1);
        cycle();
        push("prio_conf2", S_CONF, 64'h0);
        cycle();

        // RAW on r3.
        iss_en   = 1'b1;
        iss_addr = 5'd3;
        push("raw_iss", S_ISS, 64'h1);
        cycle();
        idle();
        rd(0, 3);
        rd(1, 1);
        iss_addr = 5'd3;
        push("raw_busy",   S_BUSY, 64'h1);
        push("raw_iss_no", S_ISS,  64'h0);
        cycle();
        wr(1, 3, 32'h55);
        push("raw_byp_d0",  S_D0,      64'h55);
        push("raw_byp_bsy", S_BUSY,    64'h0);
        push("raw_nb_d0",   S_NB_D0,   64'h0);
        push("raw_nb_bsy",  S_NB_BUSY, 64'h1);
        push("raw_iss_ret", S_ISS,     64'h1);
        cycle();
        idle();
        rd(0, 3);
        iss_addr = 5'd3;
        push("raw_clear_bsy", S_BUSY, 64'h0);
        push("raw_clear_d0",  S_D0,   64'h55);
        push("raw_clear_iss", S_ISS,  64'h1);
        cycle();

        // Issue and write hit r9 in the same cycle: set wins.
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        cycle();
        idle();
        wr(0, 9, 32'h99);
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        push("waw_iss", S_ISS, 64'h1);
        cycle();
        idle();
        rd(0, 9);
        iss_addr = 5'd9;
        push("waw_d0",   S_D0,   64'h99);
        push("waw_busy", S_BUSY, 64'h1);
        push("waw_iss",  S_ISS,  64'h0);
        cycle();

        // Randomised comparison against a reference model, from a clean reset.
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < NREGS; i++)
            m_regs[i] = '0;
        m_pend = '0;
        m_conf = 1'b0;
        for (int n = 0; n < 2500; n++) begin
            idle();
            for (int j = 0; j < NWR; j++) begin
                wr_en[j]                = ($urandom_range(0, 2) != 0);
                wr_addr[j*AW +: AW]     = AW'($urandom_range(0, 7));
                wr_data[j*XLEN +: XLEN] = $urandom;
            end
            for (int k = 0; k < NRD; k++)
                rd(k, $urandom_range(0, 7));
            iss_en   = ($urandom_range(0, 1) != 0);
            iss_addr = AW'($urandom_range(0, 7));
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
